// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types and constants for the mips_cpu bus slice
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } bus_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  // Encoding 2'b11 falls into the word case, so it must be word-aligned too.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = lo[0];
      default:   is_misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lane_align.sv
// rtl/mips_cpu_lane_align.sv - byte-lane enables, store placement and load extension
module mips_cpu_lane_align
  import mips_cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    byteenable = 4'b0000;
    writedata  = 32'h0;
    rdata_ext  = 32'h0;
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        rdata_ext  = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        byteenable = 4'b0011 << addr_lo;
        writedata  = {2{wdata[15:0]}};
        rdata_ext  = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byteenable = 4'b1111;
        writedata  = wdata;
        rdata_ext  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_ctrl.sv
// rtl/mips_cpu_bus_ctrl.sv - single-outstanding Avalon-style bus master for core requests
module mips_cpu_bus_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  bus_state_t  state, state_nx;
  logic [1:0]  lat_size, lat_lo;
  logic        lat_signed;
  logic [31:0] wait_cnt;
  logic [1:0]  al_size, al_lo;
  logic        al_signed;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        misaligned, timed_out, access_end;

  assign req_ready  = (state == IDLE) && reset;
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign timed_out  = (WAIT_TIMEOUT != 0) && waitrequest && (wait_cnt == WAIT_TIMEOUT - 1);
  assign access_end = !waitrequest || timed_out;

  // The aligner sees the live request while idle and the latched one during the access.
  assign al_size   = (state == IDLE) ? req_size       : lat_size;
  assign al_lo     = (state == IDLE) ? req_addr[1:0]  : lat_lo;
  assign al_signed = (state == IDLE) ? req_signed     : lat_signed;

  mips_cpu_lane_align u_lane_align (
    .size       (al_size),
    .addr_lo    (al_lo),
    .is_signed  (al_signed),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .byteenable (al_be),
    .writedata  (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = misaligned ? RESP : ACCESS;
      ACCESS:  if (access_end) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= 32'h0;
      writedata  <= 32'h0;
      byteenable <= 4'b0000;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      wait_cnt   <= 32'h0;
      lat_size   <= 2'b00;
      lat_lo     <= 2'b00;
      lat_signed <= 1'b0;
    end else begin
      state      <= state_nx;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req && misaligned) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (req) begin
            lat_size   <= req_size;
            lat_lo     <= req_addr[1:0];
            lat_signed <= req_signed;
            read       <= !req_we;
            write      <= req_we;
            address    <= {req_addr[31:2], 2'b00};
            writedata  <= al_wdata;
            byteenable <= al_be;
            wait_cnt   <= 32'h0;
          end
        end
        ACCESS: begin
          if (access_end) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= waitrequest;
            resp_rdata <= (read && !waitrequest) ? al_rdata : 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_ctrl.sv
// tb/tb_mips_cpu_bus_ctrl.sv - scoreboard bench for mips_cpu_bus_ctrl
module tb_mips_cpu_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'h0;

  mips_cpu_bus_ctrl #(.WAIT_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cycles;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];
  int checks = 0;
  int errors = 0;
  int wait_left = 0;
  logic [31:0] rd_value = 32'h0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Slave model: stall for wait_left strobe cycles, then complete.
  initial begin
    forever begin
      @(negedge clk);
      readdata = rd_value;
      if ((read || write) && wait_left > 0) begin
        waitrequest = 1'b1;
        wait_left--;
      end else begin
        waitrequest = 1'b0;
      end
    end
  end

  // Response monitor
  initial begin
    resp_exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) check("resp_pulse_width", resp_valid, 1'b0);
      if (resp_valid && !prev) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 1'b1, 1'b0);
        end else begin
          e = resp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", resp_err, e.err);
        end
      end
      prev = resp_valid;
    end
  end

  // Bus monitor: beat contents checked every strobe cycle, strobe length at its end
  initial begin
    bus_exp_t cur;
    logic active = 1'b0;
    logic cur_ok = 1'b0;
    int cnt = 0;
    forever begin
      @(negedge clk);
      if ((read || write) && !active) begin
        active = 1'b1;
        cnt = 0;
        cur_ok = (bus_q.size() != 0);
        if (cur_ok) cur = bus_q.pop_front();
        else check("bus_unexpected", 1'b1, 1'b0);
      end
      if ((read || write) && cur_ok) begin
        cnt++;
        check("bus_beat", {read, write, address, byteenable, (write ? writedata : 32'h0)},
              {!cur.we, cur.we, cur.addr, cur.be, (cur.we ? cur.wd : 32'h0)});
      end
      if (!(read || write) && active) begin
        active = 1'b0;
        if (cur_ok) check("bus_strobe_cycles", cnt, cur.cycles);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1'b1);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata, input logic [31:0] rdv,
                       input int waits, input logic bus, input logic [3:0] be,
                       input logic [31:0] wd, input int cyc, input logic [31:0] erd,
                       input logic eerr, input int elat);
    int lat = 0;
    @(negedge clk);
    wait_ready();
    wait_left = waits;
    rd_value = rdv;
    if (bus) bus_q.push_back('{we, {addr[31:2], 2'b00}, be, wd, cyc});
    resp_q.push_back('{erd, eerr});
    req = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata;
    @(posedge clk);
    #1 req = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 100);
    check("latency", lat, elat);
    wait_left = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {read, write, address, writedata, byteenable, resp_valid, resp_err},
          {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0});
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_ready_low", req_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    //     we    addr          sz     sg    wdata         rdata         wt   bus   be       wd            cyc erd           err   lat
    issue(1'b0, 32'hBFC00000, 2'b10, 1'b0, 32'h0,        32'h01494006, 0,   1'b1, 4'b1111, 32'h0,        1, 32'h01494006, 1'b0, 2);
    issue(1'b0, 32'h00000003, 2'b00, 1'b1, 32'h0,        32'h80FF1234, 0,   1'b1, 4'b1000, 32'h0,        1, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 32'h00000003, 2'b00, 1'b0, 32'h0,        32'h80FF1234, 0,   1'b1, 4'b1000, 32'h0,        1, 32'h00000080, 1'b0, 2);
    issue(1'b1, 32'h00000002, 2'b01, 1'b0, 32'hDEADBEEF, 32'h0,        0,   1'b1, 4'b1100, 32'hBEEFBEEF, 1, 32'h0,        1'b0, 2);
    issue(1'b0, 32'h00000100, 2'b10, 1'b0, 32'h0,        32'h12345678, 3,   1'b1, 4'b1111, 32'h0,        4, 32'h12345678, 1'b0, 5);
    issue(1'b0, 32'h00000002, 2'b10, 1'b0, 32'h0,        32'hFFFFFFFF, 0,   1'b0, 4'b0000, 32'h0,        0, 32'h0,        1'b1, 1);
    issue(1'b0, 32'h00000040, 2'b10, 1'b0, 32'h0,        32'hA5A5A5A5, 999, 1'b1, 4'b1111, 32'h0,        4, 32'h0,        1'b1, 5);
    issue(1'b1, 32'h00000001, 2'b00, 1'b0, 32'h000000A5, 32'h0,        0,   1'b1, 4'b0010, 32'hA5A5A5A5, 1, 32'h0,        1'b0, 2);
    issue(1'b0, 32'h00000002, 2'b01, 1'b1, 32'h0,        32'h80017FFF, 0,   1'b1, 4'b1100, 32'h0,        1, 32'hFFFF8001, 1'b0, 2);
    issue(1'b0, 32'h00000000, 2'b01, 1'b1, 32'h0,        32'h1234F00D, 1,   1'b1, 4'b0011, 32'h0,        2, 32'hFFFFF00D, 1'b0, 3);
    issue(1'b0, 32'h00000004, 2'b01, 1'b0, 32'h0,        32'h1234F00D, 0,   1'b1, 4'b0011, 32'h0,        1, 32'h0000F00D, 1'b0, 2);
    issue(1'b1, 32'h00000005, 2'b01, 1'b0, 32'h0000BEEF, 32'h0,        0,   1'b0, 4'b0000, 32'h0,        0, 32'h0,        1'b1, 1);
    issue(1'b1, 32'h00000004, 2'b11, 1'b0, 32'hCAFEF00D, 32'h0,        0,   1'b1, 4'b1111, 32'hCAFEF00D, 1, 32'h0,        1'b0, 2);
    issue(1'b0, 32'h00000001, 2'b00, 1'b1, 32'h0,        32'h00007F00, 0,   1'b1, 4'b0010, 32'h0,        1, 32'h0000007F, 1'b0, 2);

    // Reset in the middle of a stalled access: strobe drops, no response follows.
    @(negedge clk);
    wait_ready();
    wait_left = 999;
    bus_q.push_back('{1'b0, 32'h00000200, 4'b1111, 32'h0, 2});
    req = 1'b1; req_we = 1'b0; req_addr = 32'h00000200; req_size = 2'b10;
    req_signed = 1'b0; req_wdata = 32'h0;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_read", read, 1'b0);
    check("rst_mid_ready", req_ready, 1'b0);
    wait_left = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_ready_after", req_ready, 1'b1);

    issue(1'b0, 32'h00000010, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, 0, 1'b1, 4'b1111, 32'h0, 1, 32'h0BADF00D, 1'b0, 2);

    repeat (3) @(negedge clk);
    check("resp_q_empty", resp_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
